// File: rtl/cfg_mgmt_pkg.sv
// Shared types and constants for the cfg_mgmt responder: FSM states, special dword indices,
// latency counter width and the byte-enable expansion helper.
package cfg_mgmt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_HOLD
  } state_e;

  localparam int DW_ID      = 0;
  localparam int DW_CMD_STS = 1;
  localparam int DW_CLASS   = 2;
  localparam int LAT_W      = 4;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/cfg_mgmt_rsp_regfile.sv
// Config-space storage: RO ID/class dwords (debug-overridable), byte-enabled RW dwords, status
// bits in dword 1 [31:16] (W1C with set events when CFG_MGMT_RSP_W1C_EN is defined); comb read.
module cfg_mgmt_rsp_regfile
  import cfg_mgmt_pkg::*;
#(
  parameter int          NUM_DW           = 64,
  parameter logic [31:0] VENDOR_DEVICE_ID = 32'h0000_10EE,
  parameter logic [31:0] CLASS_REV        = 32'h0108_0200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [9:0]  addr,
  input  logic [7:0]  func,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  input  logic        debug,
  input  logic [15:0] status_set,
  output logic [31:0] rd_data
);

  localparam int AW = $clog2(NUM_DW);
  localparam logic [AW-1:0] IDX_STS = AW'(DW_CMD_STS);

  logic [31:0]   mem_q [NUM_DW];
  logic [31:0]   mem_d [NUM_DW];
  logic [AW-1:0] idx;
  logic          hit;
  logic          ro_dw;
  logic          wr_ok;
  logic [31:0]   mask;
  logic [31:0]   merged;

  assign idx    = addr[AW-1:0];
  assign hit    = (func == 8'd0) && (32'(addr) < NUM_DW);
  assign ro_dw  = (addr == 10'(DW_ID)) || (addr == 10'(DW_CLASS));
  assign wr_ok  = wr_en && hit && (!ro_dw || debug);
  assign mask   = be_mask(wr_be);
  assign merged = (mem_q[idx] & ~mask) | (wr_data & mask);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) begin
      mem_d[idx] = merged;
`ifdef CFG_MGMT_RSP_W1C_EN
      if (addr == 10'(DW_CMD_STS)) begin
        mem_d[idx][31:16] = mem_q[idx][31:16] & ~(wr_data[31:16] & mask[31:16]);
      end
`endif
    end
`ifdef CFG_MGMT_RSP_W1C_EN
    // Applied after the write so a set event wins over a same-cycle clear.
    mem_d[IDX_STS][31:16] = mem_d[IDX_STS][31:16] | status_set;
`endif
  end

`ifndef CFG_MGMT_RSP_W1C_EN
  logic status_set_unused;
  assign status_set_unused = ^status_set;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DW; i++) begin
        mem_q[i] <= (i == DW_ID) ? VENDOR_DEVICE_ID : (i == DW_CLASS) ? CLASS_REV : 32'h0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = hit ? mem_q[idx] : 32'h0;

endmodule

// File: rtl/cfg_mgmt_responder.sv
// cfg_mgmt target: captures a read/write request, completes it LATENCY cycles later with a
// one-cycle done pulse, then waits for the request to drop. Optional macro: CFG_MGMT_RSP_W1C_EN.
module cfg_mgmt_responder
  import cfg_mgmt_pkg::*;
#(
  parameter int          NUM_DW           = 64,
  parameter int          LATENCY          = 3,
  parameter logic [31:0] VENDOR_DEVICE_ID = 32'h0000_10EE,
  parameter logic [31:0] CLASS_REV        = 32'h0108_0200
) (
  input  logic        user_clk,
  input  logic        user_reset_n,
  input  logic [9:0]  cfg_mgmt_addr,
  input  logic [7:0]  cfg_mgmt_function_number,
  input  logic        cfg_mgmt_write,
  input  logic [31:0] cfg_mgmt_write_data,
  input  logic [3:0]  cfg_mgmt_byte_enable,
  input  logic        cfg_mgmt_read,
  input  logic        cfg_mgmt_debug_access,
  input  logic [15:0] cfg_status_set,
  output logic [31:0] cfg_mgmt_read_data,
  output logic        cfg_mgmt_read_write_done
);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [9:0]         addr_q, addr_d;
  logic [7:0]         func_q, func_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               debug_q, debug_d;
  logic               is_wr_q, is_wr_d;
  logic               done_q, done_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               commit;
  logic [31:0]        rf_rd_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    func_d    = func_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    debug_d   = debug_q;
    is_wr_d   = is_wr_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Write takes priority when both request levels are high.
        if (cfg_mgmt_write || cfg_mgmt_read) begin
          addr_d  = cfg_mgmt_addr;
          func_d  = cfg_mgmt_function_number;
          wdata_d = cfg_mgmt_write_data;
          be_d    = cfg_mgmt_byte_enable;
          debug_d = cfg_mgmt_debug_access;
          is_wr_d = cfg_mgmt_write;
          cnt_d   = LAT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          commit  = 1'b1;
          if (!is_wr_q) rd_data_d = rf_rd_data;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      ST_DONE: state_d = ST_HOLD;
      ST_HOLD: if (!cfg_mgmt_write && !cfg_mgmt_read) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      func_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      debug_q   <= 1'b0;
      is_wr_q   <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      func_q    <= func_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      debug_q   <= debug_d;
      is_wr_q   <= is_wr_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

  cfg_mgmt_rsp_regfile #(
    .NUM_DW          (NUM_DW),
    .VENDOR_DEVICE_ID(VENDOR_DEVICE_ID),
    .CLASS_REV       (CLASS_REV)
  ) u_regfile (
    .clk       (user_clk),
    .rst_n     (user_reset_n),
    .wr_en     (commit && is_wr_q),
    .addr      (addr_q),
    .func      (func_q),
    .wr_data   (wdata_q),
    .wr_be     (be_q),
    .debug     (debug_q),
    .status_set(cfg_status_set),
    .rd_data   (rf_rd_data)
  );

  assign cfg_mgmt_read_data       = rd_data_q;
  assign cfg_mgmt_read_write_done = done_q;

endmodule
